// File: rtl/rf_pkg.sv
// Shared constants and arbiter state encoding for the register-file write path.
package rf_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for outstanding MD results; flags RAW hazards to decode.
// Latency: set/clear visible one edge later; hazard lookup combinational. No backpressure.
// Register 0 can never become pending; a same-cycle set and clear of one address keeps it set.
module rf_scoreboard #(
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_vld,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_vld,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              hazard
);
    import rf_pkg::*;

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_vld) begin
            pending_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so a reissue on the accept cycle stays pending.
        if (set_vld && (set_addr != ADDR_W'(REG_ZERO))) begin
            pending_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hazard = pending_q[rs_addr] | pending_q[rt_addr];
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the RF write port between WB (fixed priority) and MD (starvation-guarded); optional RF_WB_FWD_EN bypass.
// Latency: granted write appears on rf_we/rf_waddr/rf_wdata one edge later; md_ready and hazard are combinational.
// Backpressure: MD valid/ready, forced grant with a one-cycle registered stall_req after MAX_WAIT lost cycles.
module rf_write_arbiter #(
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int MAX_WAIT = rf_pkg::MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              hazard,
    output logic              stall_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef RF_WB_FWD_EN
    ,
    output logic              fwd_rs,
    output logic              fwd_rt,
    output logic [DATA_W-1:0] fwd_data
`endif
);
    import rf_pkg::*;

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              stall_req_q, stall_req_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              in_force;
    logic              wb_grant;

    always_comb begin
        in_force    = (state_q == ARB_FORCE);
        wb_grant    = wb_valid & ~in_force;
        md_ready    = md_valid & (in_force | ~wb_valid);
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;

        if (in_force) begin
            state_d    = ARB_IDLE;
            wait_cnt_d = '0;
        end else if (md_ready || !md_valid) begin
            state_d    = ARB_IDLE;
            wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            // The IDLE-cycle loss counts too, so MD sees exactly MAX_WAIT lost cycles.
            state_d    = ARB_FORCE;
            wait_cnt_d = '0;
        end else begin
            state_d    = ARB_WAIT;
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (md_ready) begin
            rf_we_d    = (md_addr != ADDR_W'(REG_ZERO));
            rf_waddr_d = md_addr;
            rf_wdata_d = md_data;
        end else if (wb_grant) begin
            rf_we_d    = (wb_addr != ADDR_W'(REG_ZERO));
            rf_waddr_d = wb_addr;
            rf_wdata_d = wb_data;
        end

        stall_req_d = (state_d == ARB_FORCE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            wait_cnt_q  <= '0;
            stall_req_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_req_q <= stall_req_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_vld  (md_issue),
        .set_addr (md_issue_addr),
        .clr_vld  (md_ready),
        .clr_addr (md_addr),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .hazard   (hazard)
    );

    assign stall_req = stall_req_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

`ifdef RF_WB_FWD_EN
    assign fwd_rs   = rf_we_q & (rf_waddr_q == rs_addr);
    assign fwd_rt   = rf_we_q & (rf_waddr_q == rt_addr);
    assign fwd_data = rf_wdata_q;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter with default parameters (MAX_WAIT=4).
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        hazard;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .md_valid      (md_valid),
        .md_ready      (md_ready),
        .md_addr       (md_addr),
        .md_data       (md_data),
        .md_issue      (md_issue),
        .md_issue_addr (md_issue_addr),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .hazard        (hazard),
        .stall_req     (stall_req),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        md_issue = 1'b0; md_issue_addr = '0;
        rs_addr = '0; rt_addr = '0;
        #3;
        check_eq("rst_stall", stall_req, 0);
        check_eq("rst_we", rf_we, 0);
        check_eq("rst_waddr", rf_waddr, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        check_eq("rst_hazard", hazard, 0);
        #7 reset_n = 1'b1;
        step();

        // WB write, MD idle
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        #1 check_eq("wb_md_ready", md_ready, 0);
        step();
        check_eq("wb_we", rf_we, 1);
        check_eq("wb_waddr", rf_waddr, 5);
        check_eq("wb_wdata", rf_wdata, 32'hDEADBEEF);
        check_eq("wb_stall", stall_req, 0);
        wb_valid = 1'b0;

        // MD alone wins immediately
        md_valid = 1'b1; md_addr = 5'd8; md_data = 32'h0000_1234;
        #1 check_eq("md_ready_free", md_ready, 1);
        step();
        check_eq("md_waddr", rf_waddr, 8);
        check_eq("md_wdata", rf_wdata, 32'h1234);
        check_eq("md_we", rf_we, 1);
        check_eq("md_stall", stall_req, 0);
        md_valid = 1'b0;
        step();
        check_eq("idle_we", rf_we, 0);

        // Starvation guard: 4 lost cycles, then FORCE
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hA;
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h99;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("starve_ready%0d", k), md_ready, 0);
            check_eq($sformatf("starve_stall%0d", k), stall_req, 0);
            step();
        end
        check_eq("starve_wb_waddr", rf_waddr, 3);
        check_eq("force_stall", stall_req, 1);
        check_eq("force_ready", md_ready, 1);
        step();
        md_valid = 1'b0;
        check_eq("force_waddr", rf_waddr, 9);
        check_eq("force_wdata", rf_wdata, 32'h99);
        check_eq("post_force_stall", stall_req, 0);
        step();
        check_eq("wb_after_force_waddr", rf_waddr, 3);
        check_eq("wb_after_force_we", rf_we, 1);
        wb_valid = 1'b0;

        // Scoreboard
        md_issue = 1'b1; md_issue_addr = 5'd12; rs_addr = 5'd12;
        #1 check_eq("haz_before_set", hazard, 0);
        step();
        md_issue = 1'b0;
        #1 check_eq("haz_rs", hazard, 1);
        rs_addr = 5'd0; rt_addr = 5'd12;
        #1 check_eq("haz_rt", hazard, 1);
        rt_addr = 5'd13;
        #1 check_eq("haz_other", hazard, 0);
        rs_addr = 5'd12; rt_addr = 5'd0;
        md_valid = 1'b1; md_addr = 5'd12; md_data = 32'hC;
        md_issue = 1'b1; md_issue_addr = 5'd12;
        #1 check_eq("haz_reissue_ready", md_ready, 1);
        step();
        md_issue = 1'b0;
        #1 check_eq("haz_set_wins", hazard, 1);
        step();
        md_valid = 1'b0;
        #1 check_eq("haz_cleared", hazard, 0);

        // Register 0
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'h1;
        #1 check_eq("r0_ready", md_ready, 1);
        step();
        md_valid = 1'b0;
        check_eq("r0_we", rf_we, 0);
        md_issue = 1'b1; md_issue_addr = 5'd0; rs_addr = 5'd0;
        step();
        md_issue = 1'b0;
        #1 check_eq("r0_hazard", hazard, 0);

        // Reset during FORCE
        md_issue = 1'b1; md_issue_addr = 5'd7; rs_addr = 5'd7;
        step();
        md_issue = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hB;
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h55;
        repeat (4) step();
        check_eq("pre_rst_stall", stall_req, 1);
        check_eq("pre_rst_hazard", hazard, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_stall", stall_req, 0);
        check_eq("mid_rst_we", rf_we, 0);
        check_eq("mid_rst_waddr", rf_waddr, 0);
        check_eq("mid_rst_hazard", hazard, 0);
        wb_valid = 1'b0;
        md_valid = 1'b0;
        step();
        reset_n = 1'b1;
        md_valid = 1'b1; md_addr = 5'd6; md_data = 32'h66;
        #1 check_eq("post_rst_ready", md_ready, 1);
        step();
        md_valid = 1'b0;
        check_eq("post_rst_stall", stall_req, 0);
        check_eq("post_rst_waddr", rf_waddr, 6);

        // Losing counter restarts from zero after reset
        wb_valid = 1'b1; md_valid = 1'b1; md_addr = 5'd10;
        repeat (3) step();
        check_eq("post_rst_no_early_force", stall_req, 0);
        step();
        check_eq("post_rst_force", stall_req, 1);
        step();
        wb_valid = 1'b0; md_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between the pipeline writeback stage (WB) and the multi-cycle multiply/divide unit (MD).
- WB has fixed priority. MD waits behind it, under a starvation guard that briefly stalls the pipeline.
- A per-register pending scoreboard flags RAW hazards on MD destinations to decode.
- Sits between WB/MD and the register file write port (write-enable, address, data).

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (2**ADDR_W registers)
MAX_WAIT, 4, cycles MD may lose arbitration before a forced grant (>=1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
wb_valid  in  1  WB write request (no ready; held by pipeline while stall_req=1)
wb_addr  in  ADDR_W  WB destination register
wb_data  in  DATA_W  WB write data
md_valid  in  1  MD result valid; must hold addr/data stable until md_ready
md_ready  out  1  MD result accepted this cycle (combinational)
md_addr  in  ADDR_W  MD destination register
md_data  in  DATA_W  MD result
md_issue  in  1  MD op issued this cycle; marks md_issue_addr pending
md_issue_addr  in  ADDR_W  destination of issued MD op
rs_addr  in  ADDR_W  decode source 1
rt_addr  in  ADDR_W  decode source 2
hazard  out  1  rs or rt is pending on MD (combinational)
stall_req  out  1  freeze pipeline incl. WB (registered)
rf_we  out  1  register file write enable (registered)
rf_waddr  out  ADDR_W  register file write address (registered)
rf_wdata  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (async, reset_n=0): state IDLE, wait_cnt=0, pending=0, stall_req=0, rf_we=0, rf_waddr=0, rf_wdata=0. A reset mid-wait or mid-FORCE discards all in-flight state.
- States:
  - IDLE: no MD request waiting.
  - WAIT: MD request losing arbitration.
  - FORCE: stall_req=1; MD owns the port.
- Grant rules:
  - IDLE/WAIT: wb_valid wins. md_ready = md_valid & !wb_valid.
  - FORCE: wb_valid is ignored (the pipeline re-presents it next cycle). md_ready = md_valid.
- Transitions:
  - IDLE->WAIT: md_valid & wb_valid.
  - WAIT: wait_cnt increments on each lost cycle.
  - WAIT->FORCE: wait_cnt==MAX_WAIT-1 and MD loses again.
  - WAIT->IDLE: MD accepted.
  - FORCE->IDLE: always, after 1 cycle. MD is always accepted in FORCE.
  - wait_cnt clears on MD accept.
  - MD is therefore granted within MAX_WAIT+1 cycles of asserting md_valid.
- stall_req is registered: it is high exactly during the FORCE cycle.
- Write latency: 1 cycle. The granted request appears on rf_we/rf_waddr/rf_wdata on the next rising edge.
- Register 0: writes are accepted (handshake completes) but rf_we stays 0. Issues to 0 never set pending, and hazard ignores address 0.
- Scoreboard:
  - md_issue sets pending[md_issue_addr].
  - MD acceptance clears pending[md_addr].
  - Set and clear of the same address in the same cycle: set wins.
  - hazard = pending[rs_addr] | pending[rt_addr].
- Pending clears on acceptance (the rf write is one edge later); the optional forwarding path covers that gap.

Optional Feature:
RF_WB_FWD_EN
- Defined: adds outputs fwd_rs, fwd_rt (1 bit each) and fwd_data (DATA_W).
  - fwd_rs = rf_we & (rf_waddr==rs_addr); fwd_rt likewise.
  - fwd_data = rf_wdata.
  - Lets decode bypass the write committing this cycle.
- Undefined: these ports and the logic are absent. Decode must stall one extra cycle after hazard drops.

Decomposition:
- Shared package rf_pkg:
  - DATA_W/ADDR_W constants.
  - Arbiter state enum (IDLE, WAIT, FORCE).
  - REG_ZERO constant.
- One natural sub-module: rf_scoreboard (pending vector, set/clear, hazard lookup). The arbiter FSM and output registers stay in the top.

Test Plan:
- wb_valid=1 addr=5 data=0xDEADBEEF, md idle -> next edge rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; stall_req=0.
- md_valid=1 addr=8 with wb_valid=0 -> md_ready=1 same cycle; rf_waddr=8 next edge; state stays IDLE.
- MAX_WAIT=4, wb_valid held 1, md_valid=1 addr=9 -> md_ready=0 for 4 cycles, then stall_req=1 with md_ready=1; rf_waddr=9 next edge; WB write follows the cycle after.
- md_issue addr=12, rs_addr=12 -> hazard=1 until MD accept of addr 12; simultaneous reissue of 12 on accept keeps hazard=1.
- md_valid addr=0 data=0x1 -> md_ready=1, rf_we stays 0; md_issue addr=0 with rs_addr=0 -> hazard=0.
- reset_n pulsed low during FORCE -> stall_req, rf_we, pending, wait_cnt all 0 immediately; IDLE after release.
